// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM pipeline stage (master) and the
// data memory (slave).
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_we               1 store, 0 load
//   req_size             00 byte, 01 half, 10 word, 11 reserved
//   req_signed           loads: sign-extend when set
//   addr                 byte address
//   wdata                store data, right-aligned for byte/half
//   rsp_valid            one-cycle response pulse
//   rdata                load result, 0 for stores, faults and idle cycles
//   fault                misaligned address or reserved size
//   busy                 power-on clear in progress
interface data_memory_sized_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  fault;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_size, req_signed, addr, wdata,
    input  req_ready, rsp_valid, rdata, fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, addr, wdata,
    output req_ready, rsp_valid, rdata, fault, busy
  );
endinterface

// File: rtl/data_memory_sized.sv
// Single-port data memory with byte/half/word access, lane-merged stores,
// sign/zero-extended loads, alignment faults and a registered response.
// An optional clear sequence zeroes the array after reset.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   data_memory_sized_if slave port (request, response, busy)
//
// state    | meaning
// ST_CLEAR | writing zero to word[clr_cnt], one word per cycle; not ready
// ST_IDLE  | accepting one request per cycle
module data_memory_sized #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                clk,
  input logic                rst,
  data_memory_sized_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [OFF-1:0]          off;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    addr_hi_unused;
  logic                    accept;
  logic                    fault_c;
  logic [LANES-1:0]        lane_we;
  logic [DATA_WIDTH-1:0]   wdata_rep;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_shift;
  logic [DATA_WIDTH-1:0]   load_val;

  // Upper address bits are ignored, so addresses alias modulo the array size.
  assign off            = bus.addr[OFF-1:0];
  assign idx            = bus.addr[ADDR_WIDTH+OFF-1:OFF];
  assign addr_hi_unused = ^bus.addr[31:ADDR_WIDTH+OFF];

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        bus.busy = 1'b1;
        if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: begin
        bus.req_ready = 1'b1;
      end
    endcase
  end

  // A request coinciding with reset is dropped: no write, no response.
  assign accept = bus.req_valid & bus.req_ready & ~rst;

  always_comb begin
    case (bus.req_size)
      2'b00:   fault_c = 1'b0;
      2'b01:   fault_c = bus.addr[0];
      2'b10:   fault_c = (off != '0);
      default: fault_c = 1'b1;
    endcase
  end

  // Replicating the store value across lanes lets the lane mask alone pick
  // the destination bytes.
  always_comb begin
    lane_we   = '0;
    wdata_rep = bus.wdata;
    case (bus.req_size)
      2'b00:   wdata_rep = {LANES{bus.wdata[7:0]}};
      2'b01:   wdata_rep = {(LANES/2){bus.wdata[15:0]}};
      default: wdata_rep = bus.wdata;
    endcase
    if (accept && bus.req_we && !fault_c) begin
      case (bus.req_size)
        2'b00:   lane_we = LANES'(1) << off;
        2'b01:   lane_we = LANES'(3) << off;
        2'b10:   lane_we = '1;
        default: lane_we = '0;
      endcase
    end
  end

  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    case (bus.req_size)
      2'b00:   load_val = {{(DATA_WIDTH-8){bus.req_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{(DATA_WIDTH-16){bus.req_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_we[k]) mem[idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rdata     <= '0;
      bus.fault     <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.fault     <= accept & fault_c;
      bus.rdata     <= (accept && !bus.req_we && !fault_c) ? load_val : '0;
    end
  end
endmodule
